// File: rtl/pixel_fetch_if.sv
// Bank read port plus pixel stream handshake shared by pixel_fetch and its neighbours.
// master = the fetcher side, slave = bank / pixel consumer side.
interface pixel_fetch_if #(
  parameter int AMBA_WORD       = 24,
  parameter int AMBA_ADDR_DEPTH = 12,
  parameter int PIX_W           = 8
);
  logic [1:0]               bank_ctrl;
  logic [AMBA_ADDR_DEPTH:0] bank_addr;
  logic [AMBA_WORD-1:0]     bank_rdata;
  logic [PIX_W-1:0]         pix_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic                     pix_last;

  modport master (
    output bank_ctrl, bank_addr, pix_data, pix_valid, pix_last,
    input  bank_rdata, pix_ready
  );

  modport slave (
    input  bank_ctrl, bank_addr, pix_data, pix_valid, pix_last,
    output bank_rdata, pix_ready
  );
endinterface

// File: rtl/pixel_fetch.sv
// Reads N words from the pixel register bank and streams them out as LSB-first pixels.
// Optional PIXEL_FETCH_PREFETCH_EN overlaps the next word's read with the current SEND.
module pixel_fetch #(
  parameter int AMBA_WORD       = 24,
  parameter int AMBA_ADDR_DEPTH = 12,
  parameter int PIX_W           = 8,
  parameter int PIX_PER_WORD    = 3,
  parameter int BASE_ADDR       = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [AMBA_WORD-1:0] start_word,
  pixel_fetch_if.master        bus,
  output logic                 busy,
  output logic                 done
);
  localparam int ADDR_W = AMBA_ADDR_DEPTH + 1;
  localparam int N_W    = 13;
  localparam int N_LSB  = 4;
  localparam int CNT_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int N_MAX  = (1 << AMBA_ADDR_DEPTH) - BASE_ADDR;

  localparam logic [N_W-1:0]   N_MAX_V   = N_W'(N_MAX);
  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(PIX_PER_WORD - 1);
  localparam logic [1:0]       CTRL_IDLE = 2'b00;
  localparam logic [1:0]       CTRL_READ = 2'b10;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DONE} state_t;

  state_t               state_reg, state_next;
  logic                 go_prev_reg;
  logic [N_W-1:0]       n_reg, n_next;
  logic [N_W-1:0]       word_idx_reg, word_idx_next;
  logic [CNT_W-1:0]     pix_cnt_reg, pix_cnt_next;
  logic [AMBA_WORD-1:0] shift_reg, shift_next;
  logic [ADDR_W-1:0]    addr_hold_reg, addr_hold_next;

`ifdef PIXEL_FETCH_PREFETCH_EN
  typedef enum logic [1:0] {PF_NONE, PF_DATA, PF_FULL} pf_t;
  pf_t                  pf_reg, pf_next;
  logic [AMBA_WORD-1:0] spare_reg, spare_next;
  logic [ADDR_W-1:0]    next_addr;
`endif

  logic                 go_edge;
  logic [N_W-1:0]       n_field, n_clamped;
  logic                 more_words;
  logic                 last_pix;
  logic [ADDR_W-1:0]    word_addr;
  wire  [AMBA_WORD-1:0] shifted_word;
  logic                 unused_start_bits;

  assign go_edge    = start_word[0] & ~go_prev_reg;
  assign n_field    = start_word[N_LSB +: N_W];
  assign n_clamped  = (n_field > N_MAX_V) ? N_MAX_V : n_field;
  assign more_words = (word_idx_reg + N_W'(1)) < n_reg;
  assign last_pix   = (pix_cnt_reg == LAST_PIX) && !more_words;
  assign word_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx_reg);
`ifdef PIXEL_FETCH_PREFETCH_EN
  assign next_addr  = word_addr + ADDR_W'(1);
`endif
  assign unused_start_bits = ^{start_word[AMBA_WORD-1:N_LSB+N_W], start_word[N_LSB-1:1]};

  // Each lane takes the next-higher pixel; the top lane refills with zeros.
  for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
    if (gi < PIX_PER_WORD - 1) begin : g_move
      assign shifted_word[gi*PIX_W +: PIX_W] = shift_reg[(gi+1)*PIX_W +: PIX_W];
    end else begin : g_fill
      assign shifted_word[gi*PIX_W +: PIX_W] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      go_prev_reg   <= 1'b1;
      n_reg         <= '0;
      word_idx_reg  <= '0;
      pix_cnt_reg   <= '0;
      shift_reg     <= '0;
      addr_hold_reg <= '0;
`ifdef PIXEL_FETCH_PREFETCH_EN
      pf_reg        <= PF_NONE;
      spare_reg     <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      go_prev_reg   <= start_word[0];
      n_reg         <= n_next;
      word_idx_reg  <= word_idx_next;
      pix_cnt_reg   <= pix_cnt_next;
      shift_reg     <= shift_next;
      addr_hold_reg <= addr_hold_next;
`ifdef PIXEL_FETCH_PREFETCH_EN
      pf_reg        <= pf_next;
      spare_reg     <= spare_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    n_next         = n_reg;
    word_idx_next  = word_idx_reg;
    pix_cnt_next   = pix_cnt_reg;
    shift_next     = shift_reg;
    addr_hold_next = addr_hold_reg;
`ifdef PIXEL_FETCH_PREFETCH_EN
    pf_next        = pf_reg;
    spare_next     = spare_reg;
`endif
    bus.bank_ctrl  = CTRL_IDLE;
    bus.bank_addr  = addr_hold_reg;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    bus.pix_last   = 1'b0;
    busy           = (state_reg != IDLE);
    done           = 1'b0;

    case (state_reg)
      IDLE: begin
        word_idx_next = '0;
        pix_cnt_next  = '0;
        if (go_edge) begin
          n_next     = n_clamped;
          state_next = (n_field == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        bus.bank_ctrl  = CTRL_READ;
        bus.bank_addr  = word_addr;
        addr_hold_next = word_addr;
        state_next     = WAIT;
      end
      WAIT: begin
        shift_next   = bus.bank_rdata;
        pix_cnt_next = '0;
`ifdef PIXEL_FETCH_PREFETCH_EN
        pf_next      = PF_NONE;
`endif
        state_next   = SEND;
      end
      SEND: begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = shift_reg[PIX_W-1:0];
        bus.pix_last  = last_pix;
`ifdef PIXEL_FETCH_PREFETCH_EN
        // One read in flight at most: issue, then catch the data the next cycle.
        if (pf_reg == PF_NONE && more_words) begin
          bus.bank_ctrl  = CTRL_READ;
          bus.bank_addr  = next_addr;
          addr_hold_next = next_addr;
          pf_next        = PF_DATA;
        end else if (pf_reg == PF_DATA) begin
          spare_next = bus.bank_rdata;
          pf_next    = PF_FULL;
        end
`endif
        if (bus.pix_ready) begin
          shift_next = shifted_word;
          if (pix_cnt_reg == LAST_PIX) begin
            pix_cnt_next = '0;
            if (more_words) begin
              word_idx_next = word_idx_reg + N_W'(1);
`ifdef PIXEL_FETCH_PREFETCH_EN
              shift_next = (pf_reg == PF_FULL) ? spare_reg : bus.bank_rdata;
              pf_next    = PF_NONE;
`else
              state_next = REQ;
`endif
            end else begin
              state_next = DONE;
            end
          end else begin
            pix_cnt_next = pix_cnt_reg + CNT_W'(1);
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pixel_fetch.sv
// Directed vector table plus hand-written reset / clamp / throughput sequences for pixel_fetch.
// A behavioural bank answers reads one cycle after the request is sampled.
`timescale 1ns/1ps
module tb_pixel_fetch;
  localparam int BASE_ADDR = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] start_word = 24'h000011;
  logic        busy;
  logic        done;

  pixel_fetch_if #(.AMBA_WORD(24), .AMBA_ADDR_DEPTH(12), .PIX_W(8)) bus ();

  pixel_fetch #(
    .AMBA_WORD(24), .AMBA_ADDR_DEPTH(12), .PIX_W(8), .PIX_PER_WORD(3), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clock(clock), .reset(reset), .start_word(start_word), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [23:0] mem [0:4095];
  always @(posedge clock)
    if (bus.bank_ctrl == 2'b10) bus.bank_rdata <= mem[bus.bank_addr[11:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [23:0] pat_word(input int a);
    return {8'(a * 5 + 3), 8'(a * 3 + 1), 8'(a)};
  endfunction

  // Results of the most recent run.
  logic [7:0] got [$];
  bit         got_last [$];
  int r_reads, r_addr_err, r_bad_ctrl, r_stable_err, r_busy_err, r_post_err;
  int r_done_cnt, r_done_cyc, r_first_cyc, r_last_acc, r_timeout;

  task automatic run_fetch(input logic [12:0] n, input logic [15:0] pat,
                           input int retrig_at, input int max_cycles);
    int         vidx;
    bit         prev_valid, prev_ready, fin;
    logic [7:0] prev_data;
    logic       prev_last;
    got.delete();
    got_last.delete();
    r_reads = 0; r_addr_err = 0; r_bad_ctrl = 0; r_stable_err = 0; r_busy_err = 0;
    r_post_err = 0; r_done_cnt = 0; r_done_cyc = -1; r_first_cyc = -1; r_last_acc = -1;
    r_timeout = 0;
    @(negedge clock);
    start_word    = '0;
    bus.pix_ready = 1'b1;
    @(negedge clock);
    start_word = {7'b0, n, 3'b0, 1'b1};
    vidx = 0; prev_valid = 0; prev_ready = 0; prev_data = '0; prev_last = 0; fin = 0;
    for (int k = 1; k <= max_cycles && !fin; k++) begin
      @(negedge clock);
      if (r_done_cyc >= 0) begin
        if (busy || done || bus.pix_valid || bus.bank_ctrl != 2'b00) r_post_err++;
        fin = 1;
      end else begin
        if (bus.bank_ctrl == 2'b01) r_bad_ctrl++;
        if (bus.bank_ctrl == 2'b10) begin
          if (int'(bus.bank_addr) != BASE_ADDR + r_reads) r_addr_err++;
          r_reads++;
        end
        if (!busy) r_busy_err++;
        if (prev_valid && !prev_ready &&
            (!bus.pix_valid || bus.pix_data != prev_data || bus.pix_last != prev_last))
          r_stable_err++;
        if (bus.pix_valid) begin
          bus.pix_ready = (vidx < 16) ? pat[vidx] : 1'b1;
          vidx++;
          if (r_first_cyc < 0) r_first_cyc = k;
          if (bus.pix_ready) begin
            got.push_back(bus.pix_data);
            got_last.push_back(bus.pix_last);
            r_last_acc = k;
          end
        end else begin
          bus.pix_ready = 1'b1;
        end
        prev_valid = bus.pix_valid;
        prev_ready = bus.pix_ready;
        prev_data  = bus.pix_data;
        prev_last  = bus.pix_last;
        if (done) begin
          r_done_cnt++;
          r_done_cyc = k;
        end
      end
      if (retrig_at > 0 && k == retrig_at)     start_word[0] = 1'b0;
      if (retrig_at > 0 && k == retrig_at + 1) start_word[0] = 1'b1;
    end
    if (!fin) r_timeout = 1;
    start_word[0] = 1'b0;
    $display("run n=%0d pixels=%0d reads=%0d first_at=%0d done_at=%0d",
             n, got.size(), r_reads, r_first_cyc, r_done_cyc);
  endtask

  task automatic check_common(input string tag, input int npix, input int reads);
    int last_err;
    check({tag, "_timeout"}, r_timeout, 0);
    check({tag, "_npix"}, got.size(), npix);
    check({tag, "_reads"}, r_reads, reads);
    check({tag, "_addr_seq"}, r_addr_err, 0);
    check({tag, "_ctrl01"}, r_bad_ctrl, 0);
    check({tag, "_stable"}, r_stable_err, 0);
    check({tag, "_busy"}, r_busy_err, 0);
    check({tag, "_after_done"}, r_post_err, 0);
    check({tag, "_done_cnt"}, r_done_cnt, 1);
    last_err = 0;
    foreach (got_last[i]) if (got_last[i] != (i == got_last.size() - 1)) last_err++;
    check({tag, "_last"}, last_err, 0);
  endtask

  task automatic check_pat_values(input string tag);
    int         bad;
    logic [23:0] w;
    bad = 0;
    foreach (got[i]) begin
      w = pat_word(BASE_ADDR + i / 3);
      if (got[i] != w[8*(i%3) +: 8]) bad++;
    end
    check({tag, "_values"}, bad, 0);
  endtask

  typedef struct packed {
    logic [12:0] n;
    logic [23:0] w0;
    logic [23:0] w1;
    logic [15:0] pat;
    int          npix;
    int          reads;
    int          done_ser;
    int          done_pf;
    logic [47:0] px;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          busy_cnt, acc, act, exp_done, exp_span;
    bit          found;
    logic [23:0] w;
    logic [47:0] px;
    string       tag;

    vecs[0] = '{n: 13'd2, w0: 24'h030201, w1: 24'h060504, pat: 16'hFFFF,
                npix: 6, reads: 2, done_ser: 11, done_pf: 9, px: 48'h060504030201};
    vecs[1] = '{n: 13'd1, w0: 24'hCCBBAA, w1: 24'h000000, pat: 16'h0019,
                npix: 3, reads: 1, done_ser: 8, done_pf: 8, px: 48'h000000CCBBAA};
    vecs[2] = '{n: 13'd0, w0: 24'h123456, w1: 24'h000000, pat: 16'hFFFF,
                npix: 0, reads: 0, done_ser: 1, done_pf: 1, px: 48'h0};
    vecs[3] = '{n: 13'd2, w0: 24'h112233, w1: 24'h445566, pat: 16'h5555,
                npix: 6, reads: 2, done_ser: 16, done_pf: 14, px: 48'h445566112233};
    vecs[4] = '{n: 13'd1, w0: 24'hFF00FF, w1: 24'h000000, pat: 16'hFFFF,
                npix: 3, reads: 1, done_ser: 6, done_pf: 6, px: 48'h000000FF00FF};

    bus.pix_ready = 1'b1;

    // Reset state with go already high.
    repeat (3) @(negedge clock);
    check("rst_bank_ctrl", int'(bus.bank_ctrl), 0);
    check("rst_bank_addr", int'(bus.bank_addr), 0);
    check("rst_pix_valid", int'(bus.pix_valid), 0);
    check("rst_pix_data", int'(bus.pix_data), 0);
    check("rst_pix_last", int'(bus.pix_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    busy_cnt = 0;
    repeat (6) begin
      @(negedge clock);
      if (busy || done) busy_cnt++;
    end
    check("go_held_through_reset_no_run", busy_cnt, 0);

    // Directed vector table.
    for (int v = 0; v < 5; v++) begin
      tag = $sformatf("vec%0d", v);
      mem[1] = vecs[v].w0;
      mem[2] = vecs[v].w1;
      run_fetch(vecs[v].n, vecs[v].pat, 0, 200);
      check_common(tag, vecs[v].npix, vecs[v].reads);
`ifdef PIXEL_FETCH_PREFETCH_EN
      exp_done = vecs[v].done_pf;
`else
      exp_done = vecs[v].done_ser;
`endif
      check({tag, "_done_cycle"}, r_done_cyc, exp_done);
      if (vecs[v].npix > 0) check({tag, "_first_cycle"}, r_first_cyc, 3);
      px = vecs[v].px;
      for (int i = 0; i < vecs[v].npix; i++) begin
        act = (i < got.size()) ? int'(got[i]) : -1;
        check($sformatf("%s_pix%0d", tag, i), act, int'(px[8*i +: 8]));
      end
    end

    for (int a = 0; a < 4096; a++) mem[a] = pat_word(a);

    // Four-word run: throughput and read count.
    run_fetch(13'd4, 16'hFFFF, 0, 200);
    check_common("n4", 12, 4);
    check_pat_values("n4");
    check("n4_first_cycle", r_first_cyc, 3);
`ifdef PIXEL_FETCH_PREFETCH_EN
    exp_done = 15;
    exp_span = 11;
`else
    exp_done = 21;
    exp_span = 17;
`endif
    check("n4_done_cycle", r_done_cyc, exp_done);
    check("n4_pixel_span", r_last_acc - r_first_cyc, exp_span);

    // Clamp to 4095 words with a go re-edge mid-run.
    run_fetch(13'h1FFF, 16'hFFFF, 200, 21000);
    check_common("clamp", 12285, 4095);
    check_pat_values("clamp");
`ifdef PIXEL_FETCH_PREFETCH_EN
    exp_done = 12288;
`else
    exp_done = 20476;
`endif
    check("clamp_done_cycle", r_done_cyc, exp_done);

    // Reset during SEND of word 3 while go stays high.
    @(negedge clock);
    start_word    = '0;
    bus.pix_ready = 1'b1;
    @(negedge clock);
    start_word = {7'b0, 13'd8, 3'b0, 1'b1};
    found = 0;
    acc   = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clock);
      if (bus.pix_valid) begin
        if (acc == 9) found = 1;
        else acc++;
      end
    end
    check("midrun_reached_word3", int'(found), 1);
    reset = 1'b1;
    @(negedge clock);
    check("midrun_rst_valid", int'(bus.pix_valid), 0);
    check("midrun_rst_busy", int'(busy), 0);
    check("midrun_rst_ctrl", int'(bus.bank_ctrl), 0);
    check("midrun_rst_addr", int'(bus.bank_addr), 0);
    check("midrun_rst_done", int'(done), 0);
    check("midrun_rst_last", int'(bus.pix_last), 0);
    reset = 1'b0;
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (busy || done || bus.pix_valid) busy_cnt++;
    end
    check("midrun_no_restart", busy_cnt, 0);
    run_fetch(13'd1, 16'hFFFF, 0, 100);
    check_common("after_rst", 3, 1);
    w = pat_word(1);
    for (int i = 0; i < 3; i++) begin
      act = (i < got.size()) ? int'(got[i]) : -1;
      check($sformatf("after_rst_pix%0d", i), act, int'(w[8*i +: 8]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
